bcd_serial_addsub_ctrl: RTL

Digit-serial BCD adder/subtractor controller. It time-shares one instance of the one-digit BCD adder cell sum_1digit_BCD across N_DIGITS digit positions, processing one digit per clock with the least significant digit first. A start/done handshake captures the operands and returns a registered N-digit BCD result with carry or borrow. It serves as the area-saving alternative to the fully combinational multi-digit BCD adder.

---
 rtl/bcd_serial_addsub_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial BCD adder/subtractor: one shared single-digit BCD cell,
// LSD first, one digit per clock, start/done handshake.

module sum_1digit_BCD (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] z,
  output logic       c_out
);
  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
    if (raw > 5'd9) begin
      z     = raw[3:0] + 4'd6;
      c_out = 1'b1;
    end else begin
      z     = raw[3:0];
      c_out = 1'b0;
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for start; z/c_out/err hold the last result
// CHECK | validate captured operand digits
// CALC  | one digit per cycle through the shared BCD cell
// DONE  | one-cycle done pulse
module bcd_serial_addsub_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int CNT_W    = $clog2(N_DIGITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*N_DIGITS-1:0] x,
  input  logic [4*N_DIGITS-1:0] y,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] z,
  output logic                  c_out,
  output logic                  err
);
  localparam int W = 4 * N_DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CHECK, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     x_sr, y_sr, z_r, z_shift;
  logic             op_r, carry_r, c_out_r, err_r;
  logic [CNT_W-1:0] cnt;
  logic             any_bad;
  logic [3:0]       b_eff, cell_z;
  logic             cell_cout;

  // Subtraction is x + nines(y) + 1; digits are already known valid here.
  assign b_eff = op_r ? (4'd9 - y_sr[3:0]) : y_sr[3:0];

  sum_1digit_BCD u_cell (
    .a     (x_sr[3:0]),
    .b     (b_eff),
    .c_in  (carry_r),
    .z     (cell_z),
    .c_out (cell_cout)
  );

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (x_sr[4*i +: 4] > 4'd9 || y_sr[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // New digit enters at the MSD end so the LSD lands at bit 0 after N shifts.
  always_comb begin
    z_shift = z_r >> 4;
    z_shift[W-1 -: 4] = cell_z;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: state_nxt = any_bad ? DONE : CALC;
      CALC:  if (cnt == LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      x_sr    <= '0;
      y_sr    <= '0;
      z_r     <= '0;
      op_r    <= 1'b0;
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      err_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_sr    <= x;
          y_sr    <= y;
          op_r    <= op;
          carry_r <= op;
          z_r     <= '0;
        end
        CHECK: begin
          cnt <= '0;
          if (any_bad) begin
            err_r   <= 1'b1;
            z_r     <= '0;
            c_out_r <= 1'b0;
          end else begin
            err_r <= 1'b0;
          end
        end
        CALC: begin
          z_r     <= z_shift;
          x_sr    <= x_sr >> 4;
          y_sr    <= y_sr >> 4;
          carry_r <= cell_cout;
          // Register the final carry/borrow so it is stable for the DONE cycle.
          if (cnt == LAST) c_out_r <= op_r ? ~cell_cout : cell_cout;
          else             cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign z     = z_r;
  assign c_out = c_out_r;
  assign err   = err_r;
endmodule
